fetch_serializer: RTL

- Sits between the fetch stage's instruction queue and the decode stage.
- Accepts one row of INSTR_PER_FETCH fetch entries per valid/ready handshake, together with a per-slot valid mask. Slots behind a taken branch arrive masked off.
- Issues the valid entries to decode one per cycle, in ascending slot order, under a second valid/ready handshake.
- Flush discards all buffered state.

---
 rtl/fetch_serializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/fetch_serializer.sv
// Serializes a masked row of fetch entries into a one-per-cycle stream for decode.
// Optional performance counters are built when FETCH_SERIALIZER_PERF_EN is defined.
module fetch_serializer #(
    // Defaults track tortoise_pkg::INSTR_PER_FETCH and $bits(tortoise_pkg::fetch_entry_t).
    parameter int unsigned INSTR_PER_FETCH = 4,
    parameter int unsigned ENTRY_W         = 32,
    localparam int unsigned SlotW = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               flush_i,
    input  logic                               row_valid_i,
    output logic                               row_ready_o,
    input  logic [INSTR_PER_FETCH*ENTRY_W-1:0] row_i,
    input  logic [INSTR_PER_FETCH-1:0]         row_mask_i,
    output logic                               instr_valid_o,
    input  logic                               instr_ready_i,
    output logic [ENTRY_W-1:0]                 instr_o,
`ifdef FETCH_SERIALIZER_PERF_EN
    output logic [31:0]                        issued_cnt_o,
    output logic [31:0]                        stall_cnt_o,
`endif
    output logic [SlotW-1:0]                   slot_o
);

    logic [INSTR_PER_FETCH*ENTRY_W-1:0] row_q, row_d;
    logic [INSTR_PER_FETCH-1:0]         pend_q, pend_d;
    logic                               full_q, full_d;

    logic [SlotW-1:0] sel;
    logic             one_left;
    logic             xfer;
    logic             last_issue;
    logic             accept;

    // Lowest pending slot wins; an empty mask falls back to slot 0.
    always_comb begin
        sel = '0;
        for (int i = INSTR_PER_FETCH - 1; i >= 0; i--) begin
            if (pend_q[i]) sel = SlotW'(i);
        end
    end

    assign one_left      = (pend_q != '0) &&
                           ((pend_q & (pend_q - INSTR_PER_FETCH'(1))) == '0);
    assign instr_valid_o = full_q & (pend_q != '0);
    assign instr_o       = row_q[int'(sel)*ENTRY_W +: ENTRY_W];
    assign slot_o        = sel;
    assign xfer          = instr_valid_o & instr_ready_i;
    assign last_issue    = xfer & one_left;
    assign row_ready_o   = ~full_q | last_issue;
    assign accept        = row_valid_i & row_ready_o & ~flush_i;

    always_comb begin
        row_d  = row_q;
        pend_d = pend_q;
        full_d = full_q;
        if (flush_i) begin
            pend_d = '0;
            full_d = 1'b0;
        end else if (accept) begin
            row_d  = row_i;
            pend_d = row_mask_i;
            // An all-masked row is consumed without ever occupying the buffer.
            full_d = (row_mask_i != '0);
        end else if (xfer) begin
            pend_d[sel] = 1'b0;
            if (last_issue) full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row_q  <= '0;
            pend_q <= '0;
            full_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            pend_q <= pend_d;
            full_q <= full_d;
        end
    end

`ifdef FETCH_SERIALIZER_PERF_EN
    logic [31:0] issued_cnt_q, stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            if (xfer && issued_cnt_q != '1) issued_cnt_q <= issued_cnt_q + 32'd1;
            if (instr_valid_o && !instr_ready_i && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign issued_cnt_o = issued_cnt_q;
    assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
